// File: rtl/adc_peak_meter.sv
// Peak meter for a half-rectified ADC sample stream: peak-hold with timed decay and a thermometer LED bar.
// Optional sticky clip detector enabled by defining ADC_PEAK_CLIP_EN (adds ports clip and clip_clr).
module adc_peak_meter #(
    parameter int BUS_WIDTH   = 12,
    parameter int LED_COUNT   = 8,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int DECAY_DIV   = 65536,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic [BUS_WIDTH-1:0] din,
`ifdef ADC_PEAK_CLIP_EN
    input  logic                 clip_clr,
    output logic                 clip,
`endif
    output logic [BUS_WIDTH-2:0] peak,
    output logic                 peak_upd,
    output logic [LED_COUNT-1:0] level
);

    localparam int MW   = BUS_WIDTH - 1;
    localparam int HW   = $clog2(HOLD_CYCLES + 1);
    localparam int DW   = $clog2(DECAY_DIV + 1);
    localparam int STEP = (1 << MW) / LED_COUNT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MW-1:0]       peak_q, peak_d;
    logic                peak_upd_q, peak_upd_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [LED_COUNT-1:0] level_q, level_d;

    logic [MW-1:0]       mag_s;
    logic                capture_s;
    logic [MW-1:0]       decay_amt_s;
    logic [MW:0]         diff_s;
    logic [MW-1:0]       decayed_s;

    // Sample magnitude, capture qualifier and saturating decay arithmetic
    always_comb begin
        mag_s       = din[BUS_WIDTH-1] ? din[MW-1:0] : {MW{1'b0}};
        capture_s   = sample_valid && (mag_s != {MW{1'b0}}) && (mag_s >= peak_q);
        decay_amt_s = peak_q >> DECAY_SHIFT;
        if (decay_amt_s == {MW{1'b0}}) begin
            decay_amt_s = {{(MW-1){1'b0}}, 1'b1};
        end else begin
            decay_amt_s = decay_amt_s;
        end
        diff_s = {1'b0, peak_q} - {1'b0, decay_amt_s};
        if (diff_s[MW]) begin
            decayed_s = {MW{1'b0}};
        end else begin
            decayed_s = diff_s[MW-1:0];
        end
    end

    // Next-state logic: a capture overrides hold expiry and decay steps
    always_comb begin
        state_d    = state_q;
        peak_d     = peak_q;
        hold_cnt_d = hold_cnt_q;
        div_cnt_d  = div_cnt_q;
        peak_upd_d = 1'b0;
        if (capture_s) begin
            state_d    = ST_HOLD;
            peak_d     = mag_s;
            hold_cnt_d = HW'(HOLD_CYCLES - 1);
            div_cnt_d  = {DW{1'b0}};
            peak_upd_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == {HW{1'b0}}) begin
                        state_d   = ST_DECAY;
                        div_cnt_d = {DW{1'b0}};
                    end else begin
                        hold_cnt_d = hold_cnt_q - {{(HW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DECAY: begin
                    if (div_cnt_q == DW'(DECAY_DIV - 1)) begin
                        div_cnt_d = {DW{1'b0}};
                        peak_d    = decayed_s;
                        if (decayed_s == {MW{1'b0}}) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DECAY;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + {{(DW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    peak_d     = {MW{1'b0}};
                    hold_cnt_d = {HW{1'b0}};
                    div_cnt_d  = {DW{1'b0}};
                end
            endcase
        end
    end

    // Thermometer bar derived from the registered peak, one stage behind it
    always_comb begin
        level_d = {LED_COUNT{1'b0}};
        for (int i = 0; i < LED_COUNT; i++) begin
            level_d[i] = (32'(peak_q) > 32'(i * STEP));
        end
    end

    // Peak meter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            peak_q     <= {MW{1'b0}};
            peak_upd_q <= 1'b0;
            hold_cnt_q <= {HW{1'b0}};
            div_cnt_q  <= {DW{1'b0}};
            level_q    <= {LED_COUNT{1'b0}};
        end else begin
            state_q    <= state_d;
            peak_q     <= peak_d;
            peak_upd_q <= peak_upd_d;
            hold_cnt_q <= hold_cnt_d;
            div_cnt_q  <= div_cnt_d;
            level_q    <= level_d;
        end
    end

    assign peak     = peak_q;
    assign peak_upd = peak_upd_q;
    assign level    = level_q;

`ifdef ADC_PEAK_CLIP_EN
    logic clip_q, clip_d;

    // Full-scale set has priority over a simultaneous clear
    always_comb begin
        if (sample_valid && (&din)) begin
            clip_d = 1'b1;
        end else if (clip_clr) begin
            clip_d = 1'b0;
        end else begin
            clip_d = clip_q;
        end
    end

    // Sticky clip flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q <= 1'b0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip = clip_q;
`endif

endmodule

// File: tb/tb_adc_peak_meter.sv
// Directed self-checking bench for adc_peak_meter (HOLD_CYCLES=8, DECAY_DIV=2, DECAY_SHIFT=4).
// Define ADC_PEAK_CLIP_EN to also exercise the clip flag.
module tb_adc_peak_meter;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [11:0] din;
    logic [10:0] peak;
    logic        peak_upd;
    logic [7:0]  level;
`ifdef ADC_PEAK_CLIP_EN
    logic        clip_clr;
    logic        clip;
`endif

    int checks = 0;
    int passes = 0;

    adc_peak_meter #(
        .BUS_WIDTH  (12),
        .LED_COUNT  (8),
        .HOLD_CYCLES(8),
        .DECAY_DIV  (2),
        .DECAY_SHIFT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .din         (din),
`ifdef ADC_PEAK_CLIP_EN
        .clip_clr    (clip_clr),
        .clip        (clip),
`endif
        .peak        (peak),
        .peak_upd    (peak_upd),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] d);
        sample_valid = 1'b1;
        din          = d;
        tick();
        sample_valid = 1'b0;
        din          = 12'h000;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        din          = 12'h000;
`ifdef ADC_PEAK_CLIP_EN
        clip_clr     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic saw_upd;
        apply_reset();
        checks++;
        if (peak !== 11'd0) $display("FAIL reset_peak: got %0d expected 0", peak); else passes++;
        checks++;
        if (level !== 8'h00) $display("FAIL reset_level: got %h expected 00", level); else passes++;
        saw_upd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (peak_upd !== 1'b0) saw_upd = 1'b1;
        end
        checks++;
        if (saw_upd !== 1'b0) $display("FAIL reset_no_upd: got %b expected 0", saw_upd); else passes++;
    endtask

    task automatic test_capture();
        apply_reset();
        drive(12'hC00);
        checks++;
        if (peak !== 11'd1024) $display("FAIL cap_peak: got %0d expected 1024", peak); else passes++;
        checks++;
        if (peak_upd !== 1'b1) $display("FAIL cap_upd: got %b expected 1", peak_upd); else passes++;
        tick();
        checks++;
        if (level !== 8'h0F) $display("FAIL cap_level: got %h expected 0f", level); else passes++;
        checks++;
        if (peak_upd !== 1'b0) $display("FAIL cap_upd_pulse: got %b expected 0", peak_upd); else passes++;
    endtask

    task automatic test_ignore_and_hold();
        apply_reset();
        drive(12'hC00);
        drive(12'hA00);
        checks++;
        if (peak_upd !== 1'b0 || peak !== 11'd1024)
            $display("FAIL ign_smaller: got peak %0d upd %b expected 1024 0", peak, peak_upd);
        else passes++;
        drive(12'h000);
        checks++;
        if (peak_upd !== 1'b0 || peak !== 11'd1024)
            $display("FAIL ign_zero: got peak %0d upd %b expected 1024 0", peak, peak_upd);
        else passes++;
        repeat (7) tick();
        checks++;
        if (peak !== 11'd1024) $display("FAIL hold_c9: got %0d expected 1024", peak); else passes++;
        tick();
        checks++;
        if (peak !== 11'd960) $display("FAIL decay_c10: got %0d expected 960", peak); else passes++;
    endtask

    task automatic test_decay_to_idle();
        logic saw_upd;
        apply_reset();
        drive(12'h814);
        repeat (9) tick();
        checks++;
        if (peak !== 11'd20) $display("FAIL dec_start: got %0d expected 20", peak); else passes++;
        for (int k = 19; k >= 0; k--) begin
            tick();
            checks++;
            if (peak !== 11'(k)) $display("FAIL dec_step: got %0d expected %0d", peak, k); else passes++;
            if (k != 0) tick();
        end
        tick();
        checks++;
        if (level !== 8'h00) $display("FAIL dec_level: got %h expected 00", level); else passes++;
        saw_upd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (peak_upd !== 1'b0 || peak !== 11'd0) saw_upd = 1'b1;
        end
        checks++;
        if (saw_upd !== 1'b0) $display("FAIL dec_idle: got %b expected 0", saw_upd); else passes++;
    endtask

    task automatic test_capture_in_decay();
        apply_reset();
        drive(12'hA15);
        repeat (9) tick();
        tick();
        checks++;
        if (peak !== 11'd500) $display("FAIL cid_500: got %0d expected 500", peak); else passes++;
        tick();
        drive(12'hA58);
        checks++;
        if (peak !== 11'd600 || peak_upd !== 1'b1)
            $display("FAIL cid_capture: got peak %0d upd %b expected 600 1", peak, peak_upd);
        else passes++;
        repeat (9) tick();
        checks++;
        if (peak !== 11'd600) $display("FAIL cid_hold: got %0d expected 600", peak); else passes++;
        tick();
        checks++;
        if (peak !== 11'd563) $display("FAIL cid_decay: got %0d expected 563", peak); else passes++;
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        drive(12'hC00);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (peak !== 11'd0 || peak_upd !== 1'b0 || level !== 8'h00)
            $display("FAIL async_rst: got peak %0d upd %b level %h expected 0 0 00", peak, peak_upd, level);
        else passes++;
        rst_n = 1'b1;
        drive(12'h900);
        checks++;
        if (peak !== 11'd256 || peak_upd !== 1'b1)
            $display("FAIL rst_recap: got peak %0d upd %b expected 256 1", peak, peak_upd);
        else passes++;
        tick();
        checks++;
        if (level !== 8'h01) $display("FAIL rst_level: got %h expected 01", level); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] vec_din  [5] = '{12'h900, 12'hA00, 12'hA00, 12'h980, 12'hC80};
        logic [10:0] vec_peak [5] = '{11'd256, 11'd512, 11'd512, 11'd512, 11'd1152};
        logic        vec_upd  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            din          = vec_din[i];
            tick();
            checks++;
            if (peak !== vec_peak[i] || peak_upd !== vec_upd[i])
                $display("FAIL b2b_%0d: got peak %0d upd %b expected %0d %b",
                         i, peak, peak_upd, vec_peak[i], vec_upd[i]);
            else passes++;
        end
        sample_valid = 1'b0;
        din          = 12'h000;
        tick();
        checks++;
        if (level !== 8'h1F) $display("FAIL b2b_level: got %h expected 1f", level); else passes++;
    endtask

`ifdef ADC_PEAK_CLIP_EN
    task automatic test_clip();
        apply_reset();
        drive(12'hFFF);
        checks++;
        if (clip !== 1'b1 || peak !== 11'd2047)
            $display("FAIL clip_set: got clip %b peak %0d expected 1 2047", clip, peak);
        else passes++;
        tick();
        checks++;
        if (level !== 8'hFF) $display("FAIL clip_level: got %h expected ff", level); else passes++;
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
        checks++;
        if (clip !== 1'b0) $display("FAIL clip_clr: got %b expected 0", clip); else passes++;
        sample_valid = 1'b1;
        din          = 12'hFFF;
        clip_clr     = 1'b1;
        tick();
        sample_valid = 1'b0;
        din          = 12'h000;
        clip_clr     = 1'b0;
        checks++;
        if (clip !== 1'b1) $display("FAIL clip_set_wins: got %b expected 1", clip); else passes++;
        repeat (3) tick();
        checks++;
        if (clip !== 1'b1) $display("FAIL clip_sticky: got %b expected 1", clip); else passes++;
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        din          = 12'h000;
`ifdef ADC_PEAK_CLIP_EN
        clip_clr     = 1'b0;
`endif
        test_reset();
        test_capture();
        test_ignore_and_hold();
        test_decay_to_idle();
        test_capture_in_decay();
        test_reset_mid_hold();
        test_back_to_back();
`ifdef ADC_PEAK_CLIP_EN
        test_clip();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
